nes_input_event_gen: RTL and testbench

- Sits directly downstream of the NES controller receiver and turns its eight active-high pressed-level button outputs into clean, one-shot button events for game logic.
- Each button is debounced, press edges are detected, and the d-pad optionally auto-repeats.
- Pending events are coalesced into a bitmask and presented one at a time over a valid/ready interface.
- Clock is the 25 MHz system clock; 300 cycles = 12 us.

---
 rtl/nes_input_event_gen_pkg.sv | 43 ++++
 rtl/nes_input_event_gen_if.sv | 21 ++
 rtl/nes_input_event_gen_debounce.sv | 30 +++
 rtl/nes_input_event_gen.sv | 163 ++++++++++++++++
 tb/tb_nes_input_event_gen.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/nes_input_event_gen_pkg.sv
// Shared constants for the NES input event generator: event codes, button bit
// positions, repeat FSM states and the pending-mask priority encoder.
package nes_input_pkg;

    localparam logic [2:0] EV_A      = 3'd0;
    localparam logic [2:0] EV_B      = 3'd1;
    localparam logic [2:0] EV_SELECT = 3'd2;
    localparam logic [2:0] EV_START  = 3'd3;
    localparam logic [2:0] EV_UP     = 3'd4;
    localparam logic [2:0] EV_DOWN   = 3'd5;
    localparam logic [2:0] EV_LEFT   = 3'd6;
    localparam logic [2:0] EV_RIGHT  = 3'd7;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rep_state_e;

    // Lowest set index wins, so A has the highest priority; empty mask gives 0.
    function automatic logic [2:0] lowest_set_idx(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/nes_input_event_gen_if.sv
// Button/event bus of the NES input event generator. The master side is the
// event generator; the slave side is the controller receiver plus game logic.
interface nes_input_event_gen_if;
    logic [7:0] buttons;
    logic       event_ready;
    logic       overflow_clr;
    logic       event_valid;
    logic [2:0] event_code;
    logic [7:0] pressed;
    logic       overflow;

    modport master (
        input  buttons, event_ready, overflow_clr,
        output event_valid, event_code, pressed, overflow
    );

    modport slave (
        output buttons, event_ready, overflow_clr,
        input  event_valid, event_code, pressed, overflow
    );
endinterface

// File: rtl/nes_input_event_gen_debounce.sv
// Single-bit debounce filter: the level changes only after DEBOUNCE_CYCLES
// consecutive samples disagree with it.
module nes_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_r;

    // Count disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            cnt_r <= '0;
        end else if (din == level) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            level <= din;
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end
endmodule

// File: rtl/nes_input_event_gen.sv
// NES button event generator: debounce, press-edge detect, pending-event mask
// with priority presentation. Define NES_AUTOREPEAT_EN to add d-pad auto-repeat.
module nes_input_event_gen
    import nes_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 10000000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic                  clk,
    input  logic                  reset,
    nes_input_event_gen_if.master bus
);
    logic [7:0] pressed_s;
    logic [7:0] pressed_d_r;
    logic [7:0] pending_r;
    logic       overflow_r;
    logic [3:0] rep_set_s;
    logic [7:0] set_vec_s;
    logic [7:0] clr_vec_s;
    logic       event_valid_s;
    logic [2:0] event_code_s;

    for (genvar i = 0; i < 8; i++) begin : g_db
        nes_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .din  (bus.buttons[i]),
            .level(pressed_s[i])
        );
    end

`ifdef NES_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    rep_state_e  state_r;
    logic [RW-1:0] rcnt_r;
    logic [3:0]  dpad_s;
    logic [3:0]  dpad_r;

    assign dpad_s = pressed_s[BTN_RIGHT:BTN_UP];

    // Repeat fires in the same cycle the counter expires on an unchanged d-pad set.
    always_comb begin
        rep_set_s = 4'd0;
        case (state_r)
            R_DELAY: begin
                if (dpad_s != 4'd0 && dpad_s == dpad_r && rcnt_r == DELAY_LAST) begin
                    rep_set_s = dpad_s;
                end else begin
                    rep_set_s = 4'd0;
                end
            end
            R_REPEAT: begin
                if (dpad_s != 4'd0 && dpad_s == dpad_r && rcnt_r == PERIOD_LAST) begin
                    rep_set_s = dpad_s;
                end else begin
                    rep_set_s = 4'd0;
                end
            end
            default: rep_set_s = 4'd0;
        endcase
    end

    // Auto-repeat state machine; dpad_r holds last cycle's d-pad set for change detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= R_IDLE;
            rcnt_r  <= '0;
            dpad_r  <= 4'd0;
        end else begin
            dpad_r <= dpad_s;
            case (state_r)
                R_IDLE: begin
                    rcnt_r <= '0;
                    if (dpad_s != 4'd0) begin
                        state_r <= R_DELAY;
                    end else begin
                        state_r <= R_IDLE;
                    end
                end
                R_DELAY: begin
                    if (dpad_s == 4'd0) begin
                        state_r <= R_IDLE;
                        rcnt_r  <= '0;
                    end else if (dpad_s != dpad_r) begin
                        rcnt_r <= '0;
                    end else if (rcnt_r == DELAY_LAST) begin
                        state_r <= R_REPEAT;
                        rcnt_r  <= '0;
                    end else begin
                        rcnt_r <= rcnt_r + RW'(1);
                    end
                end
                R_REPEAT: begin
                    if (dpad_s == 4'd0) begin
                        state_r <= R_IDLE;
                        rcnt_r  <= '0;
                    end else if (dpad_s != dpad_r) begin
                        state_r <= R_DELAY;
                        rcnt_r  <= '0;
                    end else if (rcnt_r == PERIOD_LAST) begin
                        rcnt_r <= '0;
                    end else begin
                        rcnt_r <= rcnt_r + RW'(1);
                    end
                end
                default: begin
                    state_r <= R_IDLE;
                    rcnt_r  <= '0;
                end
            endcase
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_set_s    = 4'd0;
`endif

    assign set_vec_s     = (pressed_s & ~pressed_d_r) | {rep_set_s, 4'd0};
    assign event_valid_s = |pending_r;
    assign event_code_s  = lowest_set_idx(pending_r);

    // Only the presented event can be retired, and only on a handshake.
    always_comb begin
        clr_vec_s = 8'd0;
        if (event_valid_s && bus.event_ready) begin
            clr_vec_s = 8'd1 << event_code_s;
        end else begin
            clr_vec_s = 8'd0;
        end
    end

    // Pending mask, edge-detect history and sticky overflow; a new set beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pressed_d_r <= 8'd0;
            pending_r   <= 8'd0;
            overflow_r  <= 1'b0;
        end else begin
            pressed_d_r <= pressed_s;
            pending_r   <= (pending_r & ~clr_vec_s) | set_vec_s;
            if (|(set_vec_s & pending_r & ~clr_vec_s)) begin
                overflow_r <= 1'b1;
            end else if (bus.overflow_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign bus.pressed     = pressed_s;
    assign bus.event_valid = event_valid_s;
    assign bus.event_code  = event_code_s;
    assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_nes_input_event_gen.sv
// Randomized and directed bench for nes_input_event_gen against a behavioural
// reference model; honours NES_AUTOREPEAT_EN the same way the design does.
module tb_nes_input_event_gen;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    nes_input_event_gen_if bus ();

    nes_input_event_gen #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [7:0] m_pressed   = 8'd0;
    logic [7:0] m_last_lvl  = 8'd0;
    logic [7:0] m_pend      = 8'd0;
    logic       m_ovf       = 1'b0;
    int         m_streak [8];
    logic [3:0] m_prev_dpad = 4'd0;
    int         m_run       = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_set(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    // Advance the model by one clock using the inputs applied for that clock.
    task automatic model_step();
        logic [7:0] clr;
        logic [7:0] set;
        logic [3:0] rep;
        logic [3:0] dpad;
        if (reset) begin
            m_pressed = 8'd0; m_last_lvl = 8'd0; m_pend = 8'd0; m_ovf = 1'b0;
            m_prev_dpad = 4'd0; m_run = 0;
            for (int i = 0; i < 8; i++) m_streak[i] = 0;
        end else begin
            clr = 8'd0;
            if (m_pend != 8'd0 && bus.event_ready) clr = 8'd1 << first_set(m_pend);
            rep = 4'd0;
            dpad = m_pressed[7:4];
`ifdef NES_AUTOREPEAT_EN
            // run = number of consecutive clocks the same nonzero d-pad set was seen
            if (dpad == 4'd0) m_run = 0;
            else if (dpad == m_prev_dpad) m_run++;
            else m_run = 1;
            if (m_run >= RD + 1 && ((m_run - RD - 1) % RP) == 0) rep = dpad;
`endif
            m_prev_dpad = dpad;
            set = (m_pressed & ~m_last_lvl) | {rep, 4'd0};
            if ((set & m_pend & ~clr) != 8'd0) m_ovf = 1'b1;
            else if (bus.overflow_clr) m_ovf = 1'b0;
            m_pend = (m_pend & ~clr) | set;
            m_last_lvl = m_pressed;
            for (int i = 0; i < 8; i++) begin
                if (bus.buttons[i] == m_pressed[i]) begin
                    m_streak[i] = 0;
                end else begin
                    m_streak[i]++;
                    if (m_streak[i] == DB) begin
                        m_pressed[i] = bus.buttons[i];
                        m_streak[i] = 0;
                    end
                end
            end
        end
    endtask

    // Apply inputs for one clock, update the model on the edge, compare on the falling edge.
    task automatic cyc(input logic [7:0] b, input logic rdy, input logic oc, input logic rst);
        bus.buttons      = b;
        bus.event_ready  = rdy;
        bus.overflow_clr = oc;
        reset            = rst;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("pressed",  32'(bus.pressed),     32'(m_pressed));
        check_eq("valid",    32'(bus.event_valid), 32'(m_pend != 8'd0));
        check_eq("code",     32'(bus.event_code),  32'(first_set(m_pend)));
        check_eq("overflow", 32'(bus.overflow),    32'(m_ovf));
    endtask

    task automatic hold(input logic [7:0] b, input logic rdy, input int n);
        for (int i = 0; i < n; i++) cyc(b, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        int len;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) m_streak[i] = 0;
        bus.buttons = 8'd0; bus.event_ready = 1'b0; bus.overflow_clr = 1'b0;

        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        check_eq("reset_valid", 32'(bus.event_valid), 32'd0);

        // Glitch shorter than the debounce window
        hold(8'h01, 1'b0, 3);
        hold(8'h00, 1'b0, 8);
        check_eq("glitch_pressed", 32'(bus.pressed), 32'd0);
        check_eq("glitch_valid", 32'(bus.event_valid), 32'd0);

        // Held press, then one-cycle accept
        hold(8'h01, 1'b0, 4);
        check_eq("press_level", 32'(bus.pressed), 32'h01);
        hold(8'h01, 1'b0, 1);
        check_eq("press_valid", 32'(bus.event_valid), 32'd1);
        hold(8'h01, 1'b0, 4);
        cyc(8'h01, 1'b1, 1'b0, 1'b0);
        check_eq("press_accepted", 32'(bus.event_valid), 32'd0);
        hold(8'h00, 1'b0, 6);

        // Priority, coalesce and overflow
        hold(8'h88, 1'b0, 8);
        check_eq("prio_code", 32'(bus.event_code), 32'd3);
        hold(8'h80, 1'b0, 6);
        hold(8'h88, 1'b0, 6);
        check_eq("ovf_set", 32'(bus.overflow), 32'd1);
        cyc(8'h88, 1'b0, 1'b1, 1'b0);
        check_eq("ovf_clr", 32'(bus.overflow), 32'd0);
        cyc(8'h88, 1'b1, 1'b0, 1'b0);
        check_eq("second_code", 32'(bus.event_code), 32'd7);
        cyc(8'h88, 1'b1, 1'b0, 1'b0);
        hold(8'h00, 1'b0, 6);

        // D-pad hold, then set change
        hold(8'h10, 1'b1, 60);
        hold(8'h30, 1'b1, 40);
        hold(8'h30, 1'b0, 30);
        hold(8'h00, 1'b1, 10);

        // Reset with A held
        hold(8'h01, 1'b0, 10);
        cyc(8'h01, 1'b0, 1'b0, 1'b1);
        check_eq("rst_pressed", 32'(bus.pressed), 32'd0);
        check_eq("rst_valid", 32'(bus.event_valid), 32'd0);
        hold(8'h01, 1'b0, 4);
        check_eq("rst_quiet", 32'(bus.event_valid), 32'd0);
        hold(8'h01, 1'b0, 1);
        check_eq("rst_new_event", 32'(bus.event_valid), 32'd1);
        hold(8'h00, 1'b1, 10);

        // Randomized segments
        for (int s = 0; s < 250; s++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 2) == 0) b = b & 8'hF0;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 40));
            for (int k = 0; k < len; k++) begin
                cyc(b, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 399) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
